// File: rtl/uart_pkg.sv
// uart_pkg: shared states, parity modes and helpers for the parametrised UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop line synchroniser; UART_RX_MAJORITY_EN adds a 3-sample majority bit source
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s,
    output logic bit_s
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {meta, din_s} <= 2'b11;
        else {meta, din_s} <= {din, meta};
    end
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else hist <= {hist[0], din_s};
    end
    assign bit_s = (din_s & hist[0]) | (din_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign bit_s = din_s;
`endif
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with error flags and valid/ready holding register (majority sampling: UART_RX_MAJORITY_EN)
module uart_rx_param import uart_pkg::*; #(
    parameter int CLK_DIV     = 1042,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dvalid,
    input  logic                 dready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW   = clog2_safe(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MIN_DIV = 6;
`else
    localparam int MIN_DIV = 4;
`endif
    if (CLK_DIV < MIN_DIV || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_rx_param: illegal parameter combination");
    end
    state_t state, state_n;
    logic din_s, bit_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] bcnt;
    logic scnt, ferr, perr, tick, commit, ferr_n;
    logic [DATA_BITS-1:0] shreg;
    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .din_s(din_s),
        .bit_s(bit_s)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        tick    = cnt == CW'(CLK_DIV - 1);
        ferr_n  = ferr | ~bit_s;
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = (din_s || cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
                state_n = (!din_s && !bit_s && cnt == CW'(HALF - 1)) ? DATA : IDLE;
            end
            DATA: if (tick && bcnt == 4'(DATA_BITS - 1))
                state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            PARITY: if (tick) state_n = STOP;
            STOP: begin
                commit = tick && scnt == 1'(STOP_BITS - 1);
                if (commit) state_n = ferr_n ? BREAK : IDLE;
            end
            BREAK: begin
                cnt_n   = '0;
                state_n = din_s ? IDLE : BREAK;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt       <= '0;
            scnt       <= 1'b0;
            ferr       <= 1'b0;
            perr       <= 1'b0;
            shreg      <= '0;
            dout       <= '0;
            dvalid     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun <= commit && dvalid && !dready;
            if (state == IDLE && state_n == DATA) begin
                busy <= 1'b1;
                bcnt <= '0;
                scnt <= 1'b0;
                ferr <= 1'b0;
                perr <= 1'b0;
            end
            if (state == DATA && tick) begin
                shreg <= {bit_s, shreg[DATA_BITS-1:1]};
                bcnt  <= bcnt + 1'b1;
            end
            if (state == PARITY && tick) perr <= ^shreg ^ bit_s ^ (PARITY_MODE == PARITY_ODD);
            if (state == STOP && tick) begin
                scnt <= scnt + 1'b1;
                ferr <= ferr_n;
            end
            // a commit in the same cycle as an accept keeps dvalid high with the new word
            if (commit && (!dvalid || dready)) begin
                dout       <= shreg;
                frame_err  <= ferr_n;
                parity_err <= perr;
                dvalid     <= 1'b1;
            end else if (dvalid && dready) dvalid <= 1'b0;
            if ((commit && !ferr_n) || (state == BREAK && din_s)) busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized self-checking bench for uart_rx_param (8N1 and even-parity/2-stop instances)
module tb_uart_rx_param;
    localparam int DIV  = 16;
    localparam int HALF = DIV / 2;
    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din[2], dready[2], dvalid[2], frame_err[2], parity_err[2], overrun[2], busy[2];
    logic [7:0] dout[2];
    int checks = 0, failures = 0;
    int hi_cnt[2] = '{0, 0};
    int ov_cnt[2] = '{0, 0};
    int busy_cnt[2] = '{0, 0};
    logic pv[2] = '{1'b0, 1'b0};
    rec_t q0[$], q1[$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .din(din[0]), .dout(dout[0]), .dvalid(dvalid[0]), .dready(dready[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]), .busy(busy[0])
    );
    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .dout(dout[1]), .dvalid(dvalid[1]), .dready(dready[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]), .busy(busy[1])
    );

    // a delivered frame is dvalid newly high, or still high right after a handshake
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (dvalid[d] && (!pv[d] || dready[d])) begin
                rec_t r;
                r = '{dout[d], frame_err[d], parity_err[d]};
                if (d == 0) q0.push_back(r);
                else q1.push_back(r);
            end
            if (dvalid[d]) hi_cnt[d]++;
            if (overrun[d]) ov_cnt[d]++;
            if (busy[d]) busy_cnt[d]++;
            pv[d] = dvalid[d];
        end
    end

    task automatic drive(input int d, input logic v);
        din[d] = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] data, input int pb, input logic [1:0] stops);
        drive(d, 1'b0);
        for (int i = 0; i < 8; i++) drive(d, data[i]);
        if (pb >= 0) drive(d, pb[0]);
        for (int s = 0; s < (d == 0 ? 1 : 2); s++) drive(d, stops[s]);
        din[d] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            din[d] = 1'b1;
            dready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (dout[d] !== 8'h00) begin failures++; $display("FAIL reset_dout[%0d] got=%h exp=00", d, dout[d]); end
            checks++; if (dvalid[d] !== 1'b0) begin failures++; $display("FAIL reset_dvalid[%0d] got=%b exp=0", d, dvalid[d]); end
            checks++; if (frame_err[d] !== 1'b0) begin failures++; $display("FAIL reset_ferr[%0d] got=%b exp=0", d, frame_err[d]); end
            checks++; if (parity_err[d] !== 1'b0) begin failures++; $display("FAIL reset_perr[%0d] got=%b exp=0", d, parity_err[d]); end
            checks++; if (overrun[d] !== 1'b0) begin failures++; $display("FAIL reset_overrun[%0d] got=%b exp=0", d, overrun[d]); end
            checks++; if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, busy[d]); end
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1();
        int n, h;
        n = q0.size();
        h = hi_cnt[0];
        send(0, 8'hA5, -1, 2'b11);
        repeat (6) @(negedge clk);
        checks++; if (q0.size() !== n + 1) begin failures++; $display("FAIL a5_count got=%0d exp=%0d", q0.size(), n + 1); end
        checks++; if (q0[n].d !== 8'hA5) begin failures++; $display("FAIL a5_dout got=%h exp=a5", q0[n].d); end
        checks++; if (q0[n].fe !== 1'b0 || q0[n].pe !== 1'b0) begin failures++; $display("FAIL a5_flags got=fe%b pe%b exp=fe0 pe0", q0[n].fe, q0[n].pe); end
        checks++; if (hi_cnt[0] - h !== 1) begin failures++; $display("FAIL a5_dvalid_cycles got=%0d exp=1", hi_cnt[0] - h); end
    endtask

    task automatic test_parity();
        int n;
        n = q1.size();
        send(1, 8'h03, 1, 2'b11);
        send(1, 8'h03, 0, 2'b11);
        repeat (6) @(negedge clk);
        checks++; if (q1.size() !== n + 2) begin failures++; $display("FAIL par_count got=%0d exp=%0d", q1.size(), n + 2); end
        checks++; if (q1[n].d !== 8'h03 || q1[n].pe !== 1'b1) begin failures++; $display("FAIL par_bad got=%h/%b exp=03/1", q1[n].d, q1[n].pe); end
        checks++; if (q1[n + 1].d !== 8'h03 || q1[n + 1].pe !== 1'b0) begin failures++; $display("FAIL par_good got=%h/%b exp=03/0", q1[n + 1].d, q1[n + 1].pe); end
        checks++; if (q1[n].fe !== 1'b0 || q1[n + 1].fe !== 1'b0) begin failures++; $display("FAIL par_ferr got=%b%b exp=00", q1[n].fe, q1[n + 1].fe); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] d0, d1;
            logic [1:0] s0, s1;
            int pb, n0, n1;
            logic exp_pe;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            pb = int'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            s1 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            n0 = q0.size();
            n1 = q1.size();
            fork
                send(0, d0, -1, s0);
                send(1, d1, pb, s1);
            join
            repeat (6) @(negedge clk);
            exp_pe = (($countones(d1) + pb) % 2) != 0;
            checks++; if (q0.size() !== n0 + 1 || q0[n0].d !== d0) begin failures++; $display("FAIL rnd0_dout it%0d got=%h exp=%h", it, q0[n0].d, d0); end
            checks++; if (q0[n0].fe !== (s0[0] == 1'b0)) begin failures++; $display("FAIL rnd0_ferr it%0d got=%b exp=%b", it, q0[n0].fe, s0[0] == 1'b0); end
            checks++; if (q1.size() !== n1 + 1 || q1[n1].d !== d1) begin failures++; $display("FAIL rnd1_dout it%0d got=%h exp=%h", it, q1[n1].d, d1); end
            checks++; if (q1[n1].fe !== (s1 != 2'b11)) begin failures++; $display("FAIL rnd1_ferr it%0d got=%b exp=%b", it, q1[n1].fe, s1 != 2'b11); end
            checks++; if (q1[n1].pe !== exp_pe) begin failures++; $display("FAIL rnd1_perr it%0d got=%b exp=%b", it, q1[n1].pe, exp_pe); end
        end
    endtask

    task automatic test_break();
        int n, h;
        n = q0.size();
        h = hi_cnt[0];
        send(0, 8'h5A, -1, 2'b00);
        din[0] = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL brk_busy_low got=%b exp=1", busy[0]); end
        checks++; if (q0.size() !== n + 1 || q0[n].d !== 8'h5A || q0[n].fe !== 1'b1) begin failures++; $display("FAIL brk_frame got=%h/%b exp=5a/1", q0[n].d, q0[n].fe); end
        din[0] = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL brk_busy_end got=%b exp=0", busy[0]); end
        repeat (40) @(negedge clk);
        checks++; if (q0.size() !== n + 1 || hi_cnt[0] - h !== 1) begin failures++; $display("FAIL brk_single got=%0d/%0d exp=%0d/1", q0.size(), hi_cnt[0] - h, n + 1); end
    endtask

    task automatic test_glitch();
        int b0, b1, n0, n1;
        b0 = busy_cnt[0];
        b1 = busy_cnt[1];
        n0 = q0.size();
        n1 = q1.size();
        din[0] = 1'b0;
        din[1] = 1'b0;
        repeat (HALF - 2) @(negedge clk);
        din[0] = 1'b1;
        din[1] = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy_cnt[0] - b0 !== 0 || busy_cnt[1] - b1 !== 0) begin failures++; $display("FAIL glitch_busy got=%0d/%0d exp=0/0", busy_cnt[0] - b0, busy_cnt[1] - b1); end
        checks++; if (q0.size() !== n0 || q1.size() !== n1) begin failures++; $display("FAIL glitch_frames got=%0d/%0d exp=%0d/%0d", q0.size(), q1.size(), n0, n1); end
    endtask

    task automatic test_back_to_back();
        int n, o;
        n = q0.size();
        o = ov_cnt[0];
        dready[0] = 1'b0;
        send(0, 8'h11, -1, 2'b11);
        send(0, 8'h22, -1, 2'b11);
        repeat (6) @(negedge clk);
        checks++; if (dout[0] !== 8'h11 || dvalid[0] !== 1'b1) begin failures++; $display("FAIL ovr_hold got=%h/%b exp=11/1", dout[0], dvalid[0]); end
        checks++; if (ov_cnt[0] - o !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt[0] - o); end
        checks++; if (q0.size() !== n + 1) begin failures++; $display("FAIL ovr_frames got=%0d exp=%0d", q0.size(), n + 1); end
        dready[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dvalid[0] !== 1'b0) begin failures++; $display("FAIL ovr_accept got=%b exp=0", dvalid[0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        n = q0.size();
        drive(0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, 1'b1);
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy[0]); end
        rst = 1'b1;
        din[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy[0] !== 1'b0 || dvalid[0] !== 1'b0) begin failures++; $display("FAIL mid_after_rst got=%b/%b exp=0/0", busy[0], dvalid[0]); end
        repeat (30) @(negedge clk);
        checks++; if (q0.size() !== n) begin failures++; $display("FAIL mid_no_frame got=%0d exp=%0d", q0.size(), n); end
        send(0, 8'h3C, -1, 2'b11);
        repeat (6) @(negedge clk);
        checks++; if (q0.size() !== n + 1 || q0[n].d !== 8'h3C) begin failures++; $display("FAIL mid_3c got=%h exp=3c", q0[n].d); end
        checks++; if (q0[n].fe !== 1'b0 || q0[n].pe !== 1'b0) begin failures++; $display("FAIL mid_flags got=fe%b pe%b exp=fe0 pe0", q0[n].fe, q0[n].pe); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_random();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
